// File: rtl/sram_ana_pkg.sv
// Shared definitions for the analog-level SRAM responder: full-scale helper,
// default hysteresis thresholds and the responder FSM state encoding.
package sram_ana_pkg;

  localparam int DEF_TH_HI = 170;
  localparam int DEF_TH_LO = 85;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_SUSPECT,
    ST_FAULT
  } resp_state_t;

  function automatic int full_scale(input int ana_width);
    return (1 << ana_width) - 1;
  endfunction

endpackage

// File: rtl/ana_lane_decoder.sv
// One analog lane decoded to a bit with hysteresis; levels between the two
// thresholds keep the bit decoded on the previous clock edge.
module ana_lane_decoder
  import sram_ana_pkg::*;
#(
  parameter int ANA_WIDTH = 8,
  parameter int TH_HI     = DEF_TH_HI,
  parameter int TH_LO     = DEF_TH_LO
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ANA_WIDTH-1:0] level,
  output logic                 dec,
  output logic                 amb
);

  localparam logic [ANA_WIDTH-1:0] HI_LVL = ANA_WIDTH'(TH_HI);
  localparam logic [ANA_WIDTH-1:0] LO_LVL = ANA_WIDTH'(TH_LO);

  logic held_reg;
  logic is_hi;
  logic is_lo;

  assign is_hi = (level >= HI_LVL);
  assign is_lo = (level <= LO_LVL);
  assign amb   = !is_hi && !is_lo;
  assign dec   = is_hi ? 1'b1 : (is_lo ? 1'b0 : held_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      held_reg <= 1'b0;
    end else begin
      held_reg <= dec;
    end
  end

endmodule

// File: rtl/sram_ana_responder.sv
// SRAM responder driven by emulated analog lane levels, with a fault FSM that
// watches for an unstable write-enable. Optional stored parity: SRAM_RESP_PARITY_EN.
module sram_ana_responder
  import sram_ana_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int ANA_WIDTH    = 8,
  parameter int TH_HI        = DEF_TH_HI,
  parameter int TH_LO        = DEF_TH_LO,
  parameter int FAULT_CYCLES = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ANA_WIDTH-1:0]                 we_a,
  input  logic [ADDR_WIDTH-1:0][ANA_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0][ANA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0][ANA_WIDTH-1:0] dout_a,
  output logic                                 ambig,
  output logic                                 fault,
  output logic [7:0]                           drop_cnt
`ifdef SRAM_RESP_PARITY_EN
  ,
  output logic                                 parity_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = ($clog2(FAULT_CYCLES + 1) > 2) ? $clog2(FAULT_CYCLES + 1) : 2;
  localparam logic [CNT_W-1:0] FAULT_LIM = CNT_W'(FAULT_CYCLES);
  localparam logic [CNT_W-1:0] EXIT_LIM  = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [ANA_WIDTH-1:0] FULL  = ANA_WIDTH'(full_scale(ANA_WIDTH));

  logic                  we_dec;
  logic                  we_amb;
  logic [ADDR_WIDTH-1:0] addr_dec;
  logic [ADDR_WIDTH-1:0] addr_amb;
  logic [DATA_WIDTH-1:0] din_dec;
  logic [DATA_WIDTH-1:0] din_amb;

  ana_lane_decoder #(.ANA_WIDTH(ANA_WIDTH), .TH_HI(TH_HI), .TH_LO(TH_LO)) u_we_lane (
    .clk  (clk),
    .rst  (rst),
    .level(we_a),
    .dec  (we_dec),
    .amb  (we_amb)
  );

  for (genvar gi = 0; gi < ADDR_WIDTH; gi++) begin : g_addr_lane
    ana_lane_decoder #(.ANA_WIDTH(ANA_WIDTH), .TH_HI(TH_HI), .TH_LO(TH_LO)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .level(addr_a[gi]),
      .dec  (addr_dec[gi]),
      .amb  (addr_amb[gi])
    );
  end

  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_din_lane
    ana_lane_decoder #(.ANA_WIDTH(ANA_WIDTH), .TH_HI(TH_HI), .TH_LO(TH_LO)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .level(din_a[gi]),
      .dec  (din_dec[gi]),
      .amb  (din_amb[gi])
    );
  end

  resp_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             wr_en;
  logic             wr_drop;

  assign ambig   = we_amb || (|addr_amb) || (|din_amb);
  assign fault   = (state_reg == ST_FAULT);
  // Blocked writes in FAULT are deliberately not counted as drops.
  assign wr_en   = !fault && we_dec && !ambig;
  assign wr_drop = !fault && we_dec && ambig;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // The counter tracks ambiguous we_a cycles in SUSPECT and clean idle cycles in FAULT.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_RUN: begin
        if (we_amb) begin
          state_next = ST_SUSPECT;
          cnt_next   = CNT_ONE;
        end
      end
      ST_SUSPECT: begin
        if (!we_amb) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end else if (cnt_reg + CNT_ONE == FAULT_LIM) begin
          state_next = ST_FAULT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      ST_FAULT: begin
        if (we_amb || we_dec) begin
          cnt_next = '0;
        end else if (cnt_reg + CNT_ONE == EXIT_LIM) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = ST_RUN;
        cnt_next   = '0;
      end
    endcase
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_reg;
  logic [7:0]            drop_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_reg <= '0;
    end else begin
      if (wr_en) begin
        mem[addr_dec] <= din_dec;
      end
      rd_reg <= wr_en ? din_dec : mem[addr_dec];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_reg <= '0;
    end else if (wr_drop && (drop_reg != 8'hFF)) begin
      drop_reg <= drop_reg + 8'd1;
    end
  end

  assign drop_cnt = drop_reg;

  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_dout_lane
    assign dout_a[gi] = (!fault && rd_reg[gi]) ? FULL : '0;
  end

`ifdef SRAM_RESP_PARITY_EN
  logic par_mem [DEPTH];
  logic par_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        par_mem[i] <= 1'b0;
      end
      par_reg <= 1'b0;
    end else begin
      if (wr_en) begin
        par_mem[addr_dec] <= ^din_dec;
      end
      par_reg <= wr_en ? ^din_dec : par_mem[addr_dec];
    end
  end

  assign parity_err = !fault && ((^rd_reg) != par_reg);
`endif

endmodule

// File: tb/tb_sram_ana_responder.sv
// Self-checking bench for sram_ana_responder: vector table for the basic
// write/read sweep plus hand sequences for hysteresis, drops, FSM and reset.
module tb_sram_ana_responder;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      we_a;
  logic [3:0][7:0] addr_a;
  logic [7:0][7:0] din_a;
  logic [7:0][7:0] dout_a;
  logic            ambig;
  logic            fault;
  logic [7:0]      drop_cnt;
`ifdef SRAM_RESP_PARITY_EN
  logic            parity_err;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic [7:0] word;
  } exp_t;

  exp_t sbq[$];

  typedef struct {
    logic [7:0] we;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] exp_w;
  } vec_t;

  sram_ana_responder dut (
    .clk     (clk),
    .rst     (rst),
    .we_a    (we_a),
    .addr_a  (addr_a),
    .din_a   (din_a),
    .dout_a  (dout_a),
    .ambig   (ambig),
    .fault   (fault),
    .drop_cnt(drop_cnt)
`ifdef SRAM_RESP_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [3:0][7:0] addr_lv(input logic [3:0] b);
    logic [3:0][7:0] r;
    for (int i = 0; i < 4; i++) r[i] = b[i] ? 8'hFF : 8'h00;
    return r;
  endfunction

  function automatic logic [7:0][7:0] din_lv(input logic [7:0] b);
    logic [7:0][7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[i] ? 8'hFF : 8'h00;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // One clock of stimulus: ambig sampled mid-cycle, dout checked 1 after the edge.
  task automatic apply(input logic r, input logic [7:0] we, input logic [3:0][7:0] a,
                       input logic [7:0][7:0] d, input bit chk, input logic [7:0] exp_w,
                       input logic exp_amb, input string name);
    exp_t e;
    rst    = r;
    we_a   = we;
    addr_a = a;
    din_a  = d;
    if (chk) sbq.push_back('{name, exp_w});
    #2;
    check({name, ".ambig"}, 64'(ambig), 64'(exp_amb));
    @(posedge clk);
    #1;
    if (chk) begin
      e = sbq.pop_front();
      check({e.name, ".dout"}, 64'(dout_a), 64'(din_lv(e.word)));
    end
    $display("txn %s: rst=%0b we=%h dout=%h ambig=%0b fault=%0b drop=%0d",
             name, r, we, dout_a, ambig, fault, drop_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t            vt[32];
    logic [7:0]      ramp_lv[4];
    logic [7:0]      ramp_exp[4];
    logic            ramp_amb[4];
    logic [7:0][7:0] d;
    logic [3:0][7:0] a;

    for (int i = 0; i < 16; i++) begin
      vt[i]      = '{8'hFF, 4'(i), 8'(i), 8'(i)};
      vt[i + 16] = '{8'h00, 4'(i), 8'h00, 8'(i)};
    end
    ramp_lv  = '{8'd0, 8'd200, 8'd120, 8'd60};
    ramp_exp = '{8'd0, 8'd1, 8'd1, 8'd0};
    ramp_amb = '{1'b0, 1'b0, 1'b1, 1'b0};

    rst    = 1'b1;
    we_a   = '0;
    addr_a = '0;
    din_a  = '0;
    @(posedge clk);
    #1;
    apply(1'b1, 8'h00, addr_lv(4'd0), din_lv(8'h00), 1'b1, 8'h00, 1'b0, "reset");
    check("reset.fault", 64'(fault), 64'(1'b0));
    check("reset.drop", 64'(drop_cnt), 64'(8'd0));

    // Write i to address i (write-first read-back), then read all back.
    for (int i = 0; i < 32; i++) begin
      apply(1'b0, vt[i].we, addr_lv(vt[i].addr), din_lv(vt[i].din), 1'b1,
            vt[i].exp_w, 1'b0, $sformatf("vec%0d", i));
    end
    check("sweep.drop", 64'(drop_cnt), 64'(8'd0));

    // Ambiguous data lane during a write: dropped, old data intact.
    d = din_lv(8'hFF);
    d[3] = 8'd120;
    apply(1'b0, 8'hFF, addr_lv(4'd5), d, 1'b1, 8'd5, 1'b1, "drop_wr");
    check("drop_wr.drop", 64'(drop_cnt), 64'(8'd1));
    apply(1'b0, 8'h00, addr_lv(4'd5), din_lv(8'h00), 1'b1, 8'd5, 1'b0, "drop_rd");

    // Hysteresis on address lane 0: 0,200,120(held),60 -> reads addr 0,1,1,0.
    for (int k = 0; k < 4; k++) begin
      a = addr_lv(4'd0);
      a[0] = ramp_lv[k];
      apply(1'b0, 8'h00, a, din_lv(8'h00), 1'b1, ramp_exp[k], ramp_amb[k],
            $sformatf("ramp%0d", k));
    end

    // Short SUSPECT excursion that recovers, then a full run into FAULT.
    for (int k = 0; k < 2; k++) begin
      apply(1'b0, 8'd128, addr_lv(4'd3), din_lv(8'h00), 1'b1, 8'd3, 1'b1,
            $sformatf("susp%0d", k));
      check($sformatf("susp%0d.fault", k), 64'(fault), 64'(1'b0));
    end
    apply(1'b0, 8'h00, addr_lv(4'd3), din_lv(8'h00), 1'b1, 8'd3, 1'b0, "susp_clr");
    check("susp_clr.fault", 64'(fault), 64'(1'b0));
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, 8'd128, addr_lv(4'd3), din_lv(8'h00), 1'b1, (k < 3) ? 8'd3 : 8'd0,
            1'b1, $sformatf("amb_we%0d", k));
      check($sformatf("amb_we%0d.fault", k), 64'(fault), 64'(k == 3));
    end
    apply(1'b0, 8'hFF, addr_lv(4'd3), din_lv(8'hEE), 1'b1, 8'd0, 1'b0, "fault_wr");
    check("fault_wr.fault", 64'(fault), 64'(1'b1));
    apply(1'b0, 8'h00, addr_lv(4'd3), din_lv(8'h00), 1'b1, 8'd0, 1'b0, "exit0");
    check("exit0.fault", 64'(fault), 64'(1'b1));
    apply(1'b0, 8'h00, addr_lv(4'd3), din_lv(8'h00), 1'b1, 8'd3, 1'b0, "exit1");
    check("exit1.fault", 64'(fault), 64'(1'b0));
    check("exit1.drop", 64'(drop_cnt), 64'(8'd1));

    // Same-cycle write/read is write-first; reset beats a concurrent write.
    apply(1'b0, 8'hFF, addr_lv(4'd7), din_lv(8'hA5), 1'b1, 8'hA5, 1'b0, "wf_wr");
    apply(1'b0, 8'h00, addr_lv(4'd7), din_lv(8'h00), 1'b1, 8'hA5, 1'b0, "wf_rd");
    apply(1'b1, 8'hFF, addr_lv(4'd8), din_lv(8'h3C), 1'b1, 8'h00, 1'b0, "rst_wr");
    apply(1'b0, 8'h00, addr_lv(4'd8), din_lv(8'h00), 1'b1, 8'h00, 1'b0, "rst_rd8");
    apply(1'b0, 8'h00, addr_lv(4'd7), din_lv(8'h00), 1'b1, 8'h00, 1'b0, "rst_rd7");
    check("rst.drop", 64'(drop_cnt), 64'(8'd0));
    check("rst.fault", 64'(fault), 64'(1'b0));

    // Drop counter saturates at 255.
    d = din_lv(8'h00);
    d[0] = 8'd120;
    for (int k = 0; k < 255; k++) begin
      apply(1'b0, 8'hFF, addr_lv(4'd9), d, 1'b0, 8'h00, 1'b1, $sformatf("sat%0d", k));
    end
    check("sat.drop255", 64'(drop_cnt), 64'(8'd255));
    apply(1'b0, 8'hFF, addr_lv(4'd9), d, 1'b0, 8'h00, 1'b1, "sat_extra");
    check("sat.hold", 64'(drop_cnt), 64'(8'd255));
    apply(1'b0, 8'h00, addr_lv(4'd9), din_lv(8'h00), 1'b1, 8'h00, 1'b0, "sat_rd");

`ifdef SRAM_RESP_PARITY_EN
    apply(1'b0, 8'hFF, addr_lv(4'd2), din_lv(8'h5A), 1'b1, 8'h5A, 1'b0, "par_wr");
    check("par_wr.perr", 64'(parity_err), 64'(1'b0));
    dut.par_mem[2] = ~dut.par_mem[2];
    apply(1'b0, 8'h00, addr_lv(4'd2), din_lv(8'h00), 1'b1, 8'h5A, 1'b0, "par_rd");
    check("par_rd.perr", 64'(parity_err), 64'(1'b1));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_ana_responder.md
SRAM_ANA_RESPONDER -- requirements
Module: sram_ana_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data lanes per word.
REQ-002 Parameter ADDR_WIDTH, default 4, address lanes; depth = 2**ADDR_WIDTH.
REQ-003 Parameter ANA_WIDTH, default 8, bits per emulated analog level.
REQ-004 Parameter TH_HI, default 170, level at or above which a lane decodes 1.
REQ-005 Parameter TH_LO, default 85, level at or below which a lane decodes 0.
REQ-006 Parameter FAULT_CYCLES, default 4, consecutive ambiguous we_a cycles that trigger FAULT.
REQ-007 clk  input  1  system clock, rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 we_a  input  ANA_WIDTH  write-enable level.
REQ-010 addr_a  input  [ADDR_WIDTH] x ANA_WIDTH  address lane levels.
REQ-011 din_a  input  [DATA_WIDTH] x ANA_WIDTH  write data lane levels.
REQ-012 dout_a  output  [DATA_WIDTH] x ANA_WIDTH  read data levels, each exactly 0 or FULL_SCALE (2**ANA_WIDTH-1).
REQ-013 ambig  output  1  high when any input lane is strictly between TH_LO and TH_HI this cycle.
REQ-014 fault  output  1  high while the FSM is in FAULT.
REQ-015 drop_cnt  output  8  saturating count of dropped writes.

Function
REQ-016 Each input lane SHALL decode with hysteresis: level >= TH_HI gives 1, level <= TH_LO gives 0, and any level in between holds that lane's registered previous bit.
REQ-017 Decoded bits SHALL be combinational from the current level and the held bit, and held bits SHALL update every clk edge.
REQ-018 In RUN, when decoded we is 1 and no lane is ambiguous, mem[addr] SHALL be written with the decoded din at the clk edge.
REQ-019 When decoded we is 1 and any addr/din/we lane is ambiguous, the write SHALL be dropped and drop_cnt SHALL increment, saturating at 255.
REQ-020 Reads are registered: dout_a SHALL reflect mem[decoded addr] one clk edge after the address is presented, with latency 1.
REQ-021 Write and read of the same address in the same cycle SHALL be write-first: dout_a shows the new data.
REQ-022 FSM states: RUN, SUSPECT, FAULT.
REQ-023 RUN to SUSPECT on an ambiguous we_a, with the counter set to 1.
REQ-024 SUSPECT: an ambiguous we_a increments the counter; at counter == FAULT_CYCLES, go to FAULT; a clean we_a returns to RUN and clears the counter.
REQ-025 FAULT: writes blocked (not counted as drops), dout_a forced to 0, fault=1.
REQ-026 FAULT to RUN after 2 consecutive cycles of clean decoded we=0; a clean we=1 restarts that count.
REQ-027 Writes in SUSPECT SHALL follow REQ-018/019.
REQ-028 Address wrap is not applicable; all 2**ADDR_WIDTH decoded addresses are valid.

Reset
REQ-029 On rst, at the clk edge: state=RUN, counter=0, all held bits=0, dout_a all 0, fault=0, drop_cnt=0, all mem words=0.
REQ-030 rst during a write cycle SHALL take priority; the write is discarded.

Configuration
REQ-031 When SRAM_RESP_PARITY_EN is defined, each word SHALL store an even-parity bit computed at write time.
REQ-032 With SRAM_RESP_PARITY_EN, an output parity_err (1 bit) SHALL assert together with the registered read data whose stored parity mismatches.
REQ-033 Without SRAM_RESP_PARITY_EN, there is no parity storage and no parity_err port.

Structure
REQ-034 Package sram_ana_pkg SHALL hold the FULL_SCALE function/constant, the default thresholds, and the FSM state enum (resp_state_t).
REQ-035 Per-lane hysteresis decode SHALL be sub-module ana_lane_decoder, instantiated once per lane.

Verification
REQ-036 Write addr i = data i for i=0..15 with all lanes at 0/255, then read each -> dout_a decodes to i at read+1 cycle, drop_cnt=0.
REQ-037 Data lane 3 at 120 during write of 0xFF to addr 5 -> ambig=1, write dropped, drop_cnt=1, addr 5 still reads its previous value.
REQ-038 Lane ramped 0->200->120->60 -> decoded 0,1,1(held),0.
REQ-039 we_a=128 for 4 cycles -> RUN, SUSPECT, SUSPECT, SUSPECT, then fault=1 and dout_a=0; then we_a=0 for 2 cycles -> RUN, fault=0.
REQ-040 Write 0xA5 and read addr 7 in the same cycle -> dout_a shows 0xA5 next cycle; rst asserted during a write of 0x3C -> mem=0, dout_a=0.
REQ-041 With SRAM_RESP_PARITY_EN and a forced stored-parity flip on addr 2 -> reading addr 2 gives parity_err=1 aligned with dout_a.
